// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM engines (read, write, init).
// Holds the command encodings as {CS_N, RAS_N, CAS_N, WE_N}, the DQM
// constants, the read-engine state enumeration and a small helper for
// sizing delay counters.
package sdram_pkg;

    typedef logic [3:0] cmd_t;

    localparam cmd_t CMD_NOP       = 4'b0111;
    localparam cmd_t CMD_ACTIVE    = 4'b0011;
    localparam cmd_t CMD_READ      = 4'b0101;
    localparam cmd_t CMD_WRITE     = 4'b0100;
    localparam cmd_t CMD_PRECHARGE = 4'b0010;

    // {UDQM, LDQM}
    localparam logic [1:0] DQM_ALL  = 2'b11;
    localparam logic [1:0] DQM_NONE = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACT,
        ST_RCD,
        ST_RD,
        ST_LAT,
        ST_BURST,
        ST_PRE,
        ST_TRP
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sdram_burst_read_delay_cnt.sv
// sdram_delay_cnt: loadable down-counter with a zero flag, used to time the
// multi-cycle states of the SDRAM engines. It saturates at zero.
// Ports:
//   iclk, ireset_n  clock and synchronous active-low reset
//   load            load load_val this cycle (takes priority over counting)
//   load_val        value to load
//   zero            counter is zero (last cycle of the timed state)
module sdram_delay_cnt #(
    parameter int W = 4
) (
    input  logic         iclk,
    input  logic         ireset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block evaluation order.
    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sdram_burst_read.sv
// sdram_burst_read: one ACTIVE -> READ -> burst capture -> precharge sequence
// returning BURST_LEN words. Sits behind the bus arbiter, which owns ienb.
// Ports:
//   iclk, ireset_n          clock, synchronous active-low reset
//   ienb                    arbiter grant; DRAM_* pins are Z when low
//   ireq, irow, icolumn,    read request and operands (latched on accept)
//   ibank
//   obusy                   high from acceptance until return to IDLE
//   odata, ovalid, ofin     captured beat, per-beat strobe, last-beat pulse
//   DRAM_*                  SDRAM command/address/mask pins, DRAM_DQ data in
module sdram_burst_read
    import sdram_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ROW_W          = 13,
    parameter int COL_W          = 10,
    parameter int BANK_W         = 2,
    parameter int BURST_LEN      = 4,
    parameter int CAS_LAT        = 2,
    parameter int T_RCD          = 2,
    parameter int T_RP           = 2,
    parameter int AUTO_PRECHARGE = 1
) (
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              ienb,
    input  logic              ireq,
    input  logic [ROW_W-1:0]  irow,
    input  logic [COL_W-1:0]  icolumn,
    input  logic [BANK_W-1:0] ibank,
    output logic              obusy,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic              ofin,
    output logic              DRAM_CLK,
    output logic              DRAM_CKE,
    output logic [ROW_W-1:0]  DRAM_ADDR,
    output logic [BANK_W-1:0] DRAM_BA,
    output logic              DRAM_CS_N,
    output logic              DRAM_RAS_N,
    output logic              DRAM_CAS_N,
    output logic              DRAM_WE_N,
    output logic              DRAM_LDQM,
    output logic              DRAM_UDQM,
    input  logic [DATA_W-1:0] DRAM_DQ
);

    localparam int CNT_W = $clog2(max3(T_RCD, CAS_LAT + BURST_LEN, T_RP) + 1);

    // Each timed state loads (cycles - 1) on entry and leaves when zero.
    localparam logic [CNT_W-1:0] LD_RCD   = CNT_W'((T_RCD > 1) ? T_RCD - 2 : 0);
    localparam logic [CNT_W-1:0] LD_LAT   = CNT_W'(CAS_LAT - 2);
    localparam logic [CNT_W-1:0] LD_BURST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] LD_TRP   = CNT_W'(T_RP - 1);

    state_t             state, state_next;
    logic               accept;
    logic               cnt_load, cnt_zero;
    logic [CNT_W-1:0]   cnt_val;
    logic [COL_W-1:0]   col_q;
    logic [BANK_W-1:0]  bank_q;
    logic [ROW_W-1:0]   rd_addr;
    cmd_t               cmd_q, cmd_next;
    logic [ROW_W-1:0]   addr_q, addr_next;
    logic [BANK_W-1:0]  ba_q, ba_next;
    logic [1:0]         dqm_q, dqm_next;

    assign accept = (state == ST_IDLE) && ireq && ienb;
    assign obusy  = (state != ST_IDLE);

    sdram_delay_cnt #(.W(CNT_W)) u_delay (
        .iclk     (iclk),
        .ireset_n (ireset_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // READ address: A10 selects auto-precharge, column zero-extended below it.
    always_comb begin
        rd_addr              = '0;
        rd_addr[COL_W-1:0]   = col_q;
        rd_addr[10]          = (AUTO_PRECHARGE != 0);
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves a signal unassigned and infers a latch.
        state_next = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_ACT;
            ST_ACT: begin
                if (T_RCD > 1) begin
                    state_next = ST_RCD;
                    cnt_load   = 1'b1;
                    cnt_val    = LD_RCD;
                end else begin
                    state_next = ST_RD;
                end
            end
            ST_RCD:   if (cnt_zero) state_next = ST_RD;
            ST_RD: begin
                state_next = ST_LAT;
                cnt_load   = 1'b1;
                cnt_val    = LD_LAT;
            end
            ST_LAT: begin
                if (cnt_zero) begin
                    state_next = ST_BURST;
                    cnt_load   = 1'b1;
                    cnt_val    = LD_BURST;
                end
            end
            ST_BURST: begin
                if (cnt_zero) begin
                    if (AUTO_PRECHARGE != 0) begin
                        state_next = ST_TRP;
                        cnt_load   = 1'b1;
                        cnt_val    = LD_TRP;
                    end else begin
                        state_next = ST_PRE;
                    end
                end
            end
            ST_PRE: begin
                state_next = ST_TRP;
                cnt_load   = 1'b1;
                cnt_val    = LD_TRP;
            end
            ST_TRP:   if (cnt_zero) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so they appear registered
    // in the same cycle the FSM enters that state. ACT is only reachable on
    // acceptance, so it drives the request operands directly.
    always_comb begin
        cmd_next  = CMD_NOP;
        addr_next = '0;
        ba_next   = '0;
        dqm_next  = DQM_ALL;
        case (state_next)
            ST_ACT: begin
                cmd_next  = CMD_ACTIVE;
                addr_next = irow;
                ba_next   = ibank;
            end
            ST_RD: begin
                cmd_next  = CMD_READ;
                addr_next = rd_addr;
                ba_next   = bank_q;
                dqm_next  = DQM_NONE;
            end
            ST_LAT, ST_BURST: dqm_next = DQM_NONE;
            ST_PRE: begin
                cmd_next = CMD_PRECHARGE;
                ba_next  = bank_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            state  <= ST_IDLE;
            cmd_q  <= CMD_NOP;
            addr_q <= '0;
            ba_q   <= '0;
            dqm_q  <= DQM_ALL;
            odata  <= '0;
            ovalid <= 1'b0;
            ofin   <= 1'b0;
        end else begin
            state  <= state_next;
            cmd_q  <= cmd_next;
            addr_q <= addr_next;
            ba_q   <= ba_next;
            dqm_q  <= dqm_next;
            // Each BURST cycle ends on a beat capture; the strobe follows.
            ovalid <= (state == ST_BURST);
            ofin   <= (state == ST_BURST) && cnt_zero;
            if (state == ST_BURST) odata <= DRAM_DQ;
        end
    end

    // NOTE: operand holding registers are left out of reset; they are always
    // written on acceptance before anything reads them.
    always_ff @(posedge iclk) begin
        if (accept) begin
            col_q  <= icolumn;
            bank_q <= ibank;
        end
    end

    // The arbiter multiplexes the shared pins; release them without a grant.
    assign DRAM_CLK   = ienb ? ~iclk     : 1'bz;
    assign DRAM_CKE   = ienb ? 1'b1      : 1'bz;
    assign DRAM_ADDR  = ienb ? addr_q    : {ROW_W{1'bz}};
    assign DRAM_BA    = ienb ? ba_q      : {BANK_W{1'bz}};
    assign DRAM_CS_N  = ienb ? cmd_q[3]  : 1'bz;
    assign DRAM_RAS_N = ienb ? cmd_q[2]  : 1'bz;
    assign DRAM_CAS_N = ienb ? cmd_q[1]  : 1'bz;
    assign DRAM_WE_N  = ienb ? cmd_q[0]  : 1'bz;
    assign DRAM_LDQM  = ienb ? dqm_q[0]  : 1'bz;
    assign DRAM_UDQM  = ienb ? dqm_q[1]  : 1'bz;

endmodule

// File: tb/tb_sdram_burst_read.sv
// Self-checking bench for sdram_burst_read. Instance u_dut uses the default
// parameters; u_dut2 uses CAS_LAT 3, BURST_LEN 8 and explicit precharge.
// Each bench cycle is numbered from the acceptance edge: cycle 1 is the first
// cycle after the edge that accepted the request.
module tb_sdram_burst_read;

    typedef struct {
        logic [12:0] row;
        logic [9:0]  col;
        logic [1:0]  bank;
        logic [15:0] base;
        logic [12:0] rd_addr;
        bit          scramble;
    } vec_t;

    logic        iclk = 1'b0;
    logic        ireset_n = 1'b0;
    logic        ienb = 1'b1;
    logic        ireq = 1'b0;
    logic [12:0] irow = '0;
    logic [9:0]  icolumn = '0;
    logic [1:0]  ibank = '0;
    logic [15:0] dq1 = '0;

    wire         obusy, ovalid, ofin;
    wire  [15:0] odata;
    wire         dclk, cke, cs_n, ras_n, cas_n, we_n, ldqm, udqm;
    wire  [12:0] daddr;
    wire  [1:0]  dba;
    wire  [3:0]  cmd1 = {cs_n, ras_n, cas_n, we_n};
    wire  [1:0]  dqm1 = {udqm, ldqm};

    logic        req2 = 1'b0;
    logic [12:0] row2 = '0;
    logic [9:0]  col2 = '0;
    logic [1:0]  bank2 = '0;
    logic [15:0] dq2 = '0;
    wire         busy2, valid2, fin2;
    wire  [15:0] data2;
    wire         dclk2, cke2, cs2, ras2, cas2, we2, ldqm2, udqm2;
    wire  [12:0] addr2;
    wire  [1:0]  ba2;
    wire  [3:0]  cmd2 = {cs2, ras2, cas2, we2};

    int n_checks = 0;
    int n_fail = 0;

    sdram_burst_read u_dut (
        .iclk(iclk), .ireset_n(ireset_n), .ienb(ienb), .ireq(ireq),
        .irow(irow), .icolumn(icolumn), .ibank(ibank),
        .obusy(obusy), .odata(odata), .ovalid(ovalid), .ofin(ofin),
        .DRAM_CLK(dclk), .DRAM_CKE(cke), .DRAM_ADDR(daddr), .DRAM_BA(dba),
        .DRAM_CS_N(cs_n), .DRAM_RAS_N(ras_n), .DRAM_CAS_N(cas_n), .DRAM_WE_N(we_n),
        .DRAM_LDQM(ldqm), .DRAM_UDQM(udqm), .DRAM_DQ(dq1)
    );

    sdram_burst_read #(.CAS_LAT(3), .BURST_LEN(8), .AUTO_PRECHARGE(0)) u_dut2 (
        .iclk(iclk), .ireset_n(ireset_n), .ienb(1'b1), .ireq(req2),
        .irow(row2), .icolumn(col2), .ibank(bank2),
        .obusy(busy2), .odata(data2), .ovalid(valid2), .ofin(fin2),
        .DRAM_CLK(dclk2), .DRAM_CKE(cke2), .DRAM_ADDR(addr2), .DRAM_BA(ba2),
        .DRAM_CS_N(cs2), .DRAM_RAS_N(ras2), .DRAM_CAS_N(cas2), .DRAM_WE_N(we2),
        .DRAM_LDQM(ldqm2), .DRAM_UDQM(udqm2), .DRAM_DQ(dq2)
    );

    always #5 iclk = ~iclk;

    // SDRAM data model: after a READ seen in cycle n, beat k is on DQ during
    // cycle n+CL+k; anything else is a filler pattern.
    int          cyc = 0;
    int          rd1_cyc = -100;
    int          rd2_cyc = -100;
    int          d1, d2;
    logic [15:0] base1 = '0;
    logic [15:0] base2 = '0;

    always @(negedge iclk) begin
        cyc = cyc + 1;
        if (ienb && cmd1 == 4'b0101) rd1_cyc = cyc;
        if (cmd2 == 4'b0101) rd2_cyc = cyc;
        d1 = cyc - rd1_cyc - 2;
        d2 = cyc - rd2_cyc - 3;
        dq1 = (d1 >= 0 && d1 < 4) ? base1 + 16'(d1) : 16'h5A5A;
        dq2 = (d2 >= 0 && d2 < 8) ? base2 + 16'(d2) : 16'hA5A5;
    end

    task automatic check(input string name, input int c, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, c, act, exp);
        end
    endtask

    // One default-parameter transaction, checked cycle by cycle.
    // Expected: ACT 1, RCD 2, READ 3, LAT 4, BURST 5-8, TRP 9-10, IDLE 11.
    task automatic run_vec(input vec_t v);
        logic [3:0] exp_cmd;
        bit         exp_valid;
        @(negedge iclk);
        base1   = v.base;
        irow    = v.row;
        icolumn = v.col;
        ibank   = v.bank;
        ireq    = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge iclk);
            if (i == 1) begin
                ireq = 1'b0;
                if (v.scramble) begin
                    irow    = ~v.row;
                    icolumn = ~v.col;
                    ibank   = ~v.bank;
                end
            end
            exp_cmd   = (i == 1) ? 4'b0011 : (i == 3) ? 4'b0101 : 4'b0111;
            exp_valid = (i >= 6 && i <= 9);
            check("cmd", i, 32'(cmd1), 32'(exp_cmd));
            check("obusy", i, 32'(obusy), 32'(i <= 10));
            check("ovalid", i, 32'(ovalid), 32'(exp_valid));
            check("ofin", i, 32'(ofin), 32'(i == 9));
            if (exp_valid) check("odata", i, 32'(odata), 32'(v.base + 16'(i - 6)));
            if (i == 1) begin
                check("act_addr", i, 32'(daddr), 32'(v.row));
                check("act_ba", i, 32'(dba), 32'(v.bank));
            end
            if (i == 3) begin
                check("rd_addr", i, 32'(daddr), 32'(v.rd_addr));
                check("rd_ba", i, 32'(dba), 32'(v.bank));
            end
            if (i >= 3 && i <= 8) check("dqm_open", i, 32'(dqm1), 32'h0);
            if (i >= 9) check("dqm_closed", i, 32'(dqm1), 32'h3);
        end
    endtask

    vec_t vecs[4];
    int   act_n, val_n, fin_n;
    int   act_pos[4];
    logic [3:0] exp2;

    initial begin
        vecs[0] = '{13'h1ABC, 10'h040, 2'd2, 16'hA000, 13'h0440, 1'b0};
        vecs[1] = '{13'h0000, 10'h000, 2'd0, 16'h0000, 13'h0400, 1'b0};
        vecs[2] = '{13'h1FFF, 10'h3FC, 2'd3, 16'hFFFC, 13'h07FC, 1'b0};
        vecs[3] = '{13'h0555, 10'h2A8, 2'd1, 16'h1234, 13'h06A8, 1'b1};

        // Reset state.
        repeat (3) @(negedge iclk);
        check("rst_cmd", 0, 32'(cmd1), 32'h7);
        check("rst_dqm", 0, 32'(dqm1), 32'h3);
        check("rst_addr", 0, 32'(daddr), 32'h0);
        check("rst_ba", 0, 32'(dba), 32'h0);
        check("rst_busy", 0, 32'(obusy), 32'h0);
        check("rst_valid", 0, 32'(ovalid), 32'h0);
        check("rst_fin", 0, 32'(ofin), 32'h0);
        check("rst_data", 0, 32'(odata), 32'h0);
        check("dram_clk", 0, 32'(dclk === 1'b1), 32'h1);
        check("dram_cke", 0, 32'(cke === 1'b1), 32'h1);
        ireset_n = 1'b1;

        // Table-driven transactions, including operands changed after accept.
        for (int t = 0; t < 4; t++) run_vec(vecs[t]);

        // Request held high: second ACTIVE after one IDLE cycle past TRP.
        @(negedge iclk);
        base1 = 16'hC000; irow = 13'h0A0A; icolumn = 10'h010; ibank = 2'd1;
        ireq = 1'b1;
        act_n = 0; val_n = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge iclk);
            if (i == 20) ireq = 1'b0;
            if (cmd1 == 4'b0011) begin
                if (act_n < 4) act_pos[act_n] = i;
                act_n++;
            end
            if (ovalid) val_n++;
            if (i == 11) check("b2b_idle_gap", i, 32'(obusy), 32'h0);
            if (i == 12) check("b2b_reaccept", i, 32'(obusy), 32'h1);
        end
        check("b2b_act_count", 24, 32'(act_n), 32'd2);
        check("b2b_act0_pos", 24, 32'(act_pos[0]), 32'd1);
        check("b2b_act1_pos", 24, 32'(act_pos[1]), 32'd12);
        check("b2b_beats", 24, 32'(val_n), 32'd8);

        // Reset during BURST after two beats.
        @(negedge iclk);
        base1 = 16'hB000; ireq = 1'b1;
        val_n = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge iclk);
            if (i == 1) ireq = 1'b0;
            if (ovalid) val_n++;
        end
        check("pre_rst_beats", 7, 32'(val_n), 32'd2);
        ireset_n = 1'b0;
        @(negedge iclk);
        check("mid_rst_cmd", 8, 32'(cmd1), 32'h7);
        check("mid_rst_dqm", 8, 32'(dqm1), 32'h3);
        check("mid_rst_busy", 8, 32'(obusy), 32'h0);
        check("mid_rst_valid", 8, 32'(ovalid), 32'h0);
        ireset_n = 1'b1;
        val_n = 0; fin_n = 0;
        for (int i = 9; i <= 16; i++) begin
            @(negedge iclk);
            if (ovalid) val_n++;
            if (ofin) fin_n++;
            if (obusy) fin_n++;
        end
        check("post_rst_quiet", 16, 32'(val_n + fin_n), 32'd0);

        // No grant: request ignored and pins released.
        @(negedge iclk);
        ienb = 1'b0; ireq = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge iclk);
            check("nogrant_busy", i, 32'(obusy), 32'h0);
            check("nogrant_cs_z", i, 32'(cs_n === 1'bz), 32'h1);
            check("nogrant_cke_z", i, 32'(cke === 1'bz), 32'h1);
        end
        ireq = 1'b0; ienb = 1'b1;
        @(negedge iclk);
        check("nogrant_after", 0, 32'(obusy), 32'h0);

        // Grant dropped mid-burst: pins Z, FSM and capture continue.
        base1 = 16'hD000; ireq = 1'b1;
        val_n = 0; fin_n = 0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge iclk);
            if (i == 1) ireq = 1'b0;
            if (i == 6) ienb = 1'b0;
            if (i == 7) begin
                check("drop_ras_z", i, 32'(ras_n === 1'bz), 32'h1);
                check("drop_clk_z", i, 32'(dclk === 1'bz), 32'h1);
            end
            if (ovalid) val_n++;
            if (ofin) fin_n++;
            if (i == 9) check("drop_last_data", i, 32'(odata), 32'h0000D003);
            if (i == 11) ienb = 1'b1;
        end
        check("drop_beats", 11, 32'(val_n), 32'd4);
        check("drop_fin", 11, 32'(fin_n), 32'd1);
        check("drop_idle", 11, 32'(obusy), 32'h0);

        // CL 3, BL 8, explicit precharge: READ 3, beats 7-14, PRE 14, idle 17.
        @(negedge iclk);
        base2 = 16'h7000; row2 = 13'h0123; col2 = 10'h008; bank2 = 2'd1;
        req2 = 1'b1;
        val_n = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge iclk);
            if (i == 1) req2 = 1'b0;
            exp2 = (i == 1) ? 4'b0011 : (i == 3) ? 4'b0101 :
                   (i == 14) ? 4'b0010 : 4'b0111;
            check("d2_cmd", i, 32'(cmd2), 32'(exp2));
            check("d2_busy", i, 32'(busy2), 32'(i <= 16));
            check("d2_valid", i, 32'(valid2), 32'(i >= 7 && i <= 14));
            check("d2_fin", i, 32'(fin2), 32'(i == 14));
            if (valid2) begin
                check("d2_data", i, 32'(data2), 32'(16'h7000 + 16'(i - 7)));
                val_n++;
            end
            if (i == 3) check("d2_rd_addr", i, 32'(addr2), 32'h0008);
            if (i == 14) begin
                check("d2_pre_a10", i, 32'(addr2[10]), 32'h0);
                check("d2_pre_ba", i, 32'(ba2), 32'h1);
            end
        end
        check("d2_beats", 18, 32'(val_n), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
